// File: rtl/csr_file_pkg.sv
// rtl/csr_file_pkg.sv - shared opcode, state and default definitions for the CSR file
//
// Purpose: single home for CSR request opcodes and FSM state encodings so the
//          register file, its counter and any bus front-end agree on them.
// Contents: csr_op_e (RD/WR/SET/CLR), csr_state_e (IDLE/RESP), default sizes,
//           csr_op_is_write() helper.
package csr_file_pkg;

    localparam int CSR_DATA_W_DEF = 24;
    localparam int CSR_NUM_DEF    = 16;

    typedef enum logic [1:0] {
        CSR_OP_RD  = 2'd0,
        CSR_OP_WR  = 2'd1,
        CSR_OP_SET = 2'd2,
        CSR_OP_CLR = 2'd3
    } csr_op_e;

    typedef enum logic {
        CSR_ST_IDLE = 1'b0,
        CSR_ST_RESP = 1'b1
    } csr_state_e;

    // Every opcode other than RD modifies the target register.
    function automatic logic csr_op_is_write(input csr_op_e op);
        return (op != CSR_OP_RD);
    endfunction

endpackage

// File: rtl/csr_cycle_ctr.sv
// rtl/csr_cycle_ctr.sv - free-running 2*HALF_W cycle counter with per-half load
//
// Purpose: counts every clock out of reset, wrapping to zero. A load of either
//          half replaces that half and suppresses the increment for the whole
//          counter on that edge, so the written value is exactly what is seen next.
// Ports:
//   iw_clk, iw_rst_n           clock, asynchronous active-low reset
//   iw_ld_lo / iw_ld_lo_data   load strobe and value for the low half
//   iw_ld_hi / iw_ld_hi_data   load strobe and value for the high half
//   ow_count                   current counter value
module csr_cycle_ctr #(
    parameter int HALF_W = 24
) (
    input  logic                  iw_clk,
    input  logic                  iw_rst_n,
    input  logic                  iw_ld_lo,
    input  logic [HALF_W-1:0]     iw_ld_lo_data,
    input  logic                  iw_ld_hi,
    input  logic [HALF_W-1:0]     iw_ld_hi_data,
    output logic [2*HALF_W-1:0]   ow_count
);

    logic [2*HALF_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (iw_ld_lo || iw_ld_hi) begin
            // The half not being loaded holds; no increment on a load edge.
            cnt_d = cnt_q;
            if (iw_ld_lo) cnt_d[HALF_W-1:0]        = iw_ld_lo_data;
            if (iw_ld_hi) cnt_d[2*HALF_W-1:HALF_W] = iw_ld_hi_data;
        end
    end

    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) cnt_q <= '0;
        else           cnt_q <= cnt_d;
    end

    assign ow_count = cnt_q;

endmodule

// File: rtl/csr_file.sv
// rtl/csr_file.sv - CSR register file with RD/WR/SET/CLR requests and 1-cycle responses
//
// Purpose: NUM_CSR registers of DATA_W bits. The top two indices alias the low
//          and high halves of a free-running cycle counter. Each accepted request
//          updates its register and captures the pre-operation value on the same
//          edge; the response is presented one cycle later and held until taken.
// Ports:
//   iw_clk, iw_rst_n                 clock, asynchronous active-low reset
//   iw_req_valid / ow_req_ready      request handshake
//   iw_req_op, iw_req_idx, iw_req_wdata  opcode, register index, operand
//   iw_flush                         drop any held response, block new requests
//   ow_rsp_valid / iw_rsp_ready      response handshake
//   ow_rsp_rdata, ow_rsp_err         pre-operation value, error flag
//   ow_cycle                         full cycle counter value
module csr_file
    import csr_file_pkg::*;
#(
    parameter int                 DATA_W  = CSR_DATA_W_DEF,
    parameter int                 NUM_CSR = CSR_NUM_DEF,
    parameter logic [NUM_CSR-1:0] RO_MASK = '0,
    localparam int                IDX_W   = $clog2(NUM_CSR)
) (
    input  logic                  iw_clk,
    input  logic                  iw_rst_n,
    input  logic                  iw_req_valid,
    output logic                  ow_req_ready,
    input  logic [1:0]            iw_req_op,
    input  logic [IDX_W-1:0]      iw_req_idx,
    input  logic [DATA_W-1:0]     iw_req_wdata,
    input  logic                  iw_flush,
    output logic                  ow_rsp_valid,
    input  logic                  iw_rsp_ready,
    output logic [DATA_W-1:0]     ow_rsp_rdata,
    output logic                  ow_rsp_err,
    output logic [2*DATA_W-1:0]   ow_cycle
);

    localparam logic [IDX_W:0]   NUM_CSR_X  = (IDX_W+1)'(NUM_CSR);
    localparam logic [IDX_W-1:0] CTR_LO_IDX = IDX_W'(NUM_CSR - 2);
    localparam logic [IDX_W-1:0] CTR_HI_IDX = IDX_W'(NUM_CSR - 1);

    csr_state_e                       state_q, state_d;
    logic [NUM_CSR-1:0][DATA_W-1:0]   csr_q, csr_d;
    logic [DATA_W-1:0]                rsp_rdata_q, rsp_rdata_d;
    logic                             rsp_err_q, rsp_err_d;

    csr_op_e             op;
    logic                accept;
    logic                in_range;
    logic                is_ctr_lo;
    logic                is_ctr_hi;
    logic                is_wr;
    logic                ro_hit;
    logic                req_err;
    logic                do_update;
    logic                ld_lo;
    logic                ld_hi;
    logic [DATA_W-1:0]   cur_val;
    logic [DATA_W-1:0]   new_val;
    logic [2*DATA_W-1:0] ctr_val;

    assign op = csr_op_e'(iw_req_op);

    // Reset and flush both block acceptance; in RESP a new request is only
    // taken when the held response is being consumed on the same edge.
    assign ow_req_ready = iw_rst_n & ~iw_flush &
                          ((state_q == CSR_ST_IDLE) | iw_rsp_ready);
    assign accept       = iw_req_valid & ow_req_ready;

    // Request decode and operand computation.
    always_comb begin
        in_range  = ({1'b0, iw_req_idx} < NUM_CSR_X);
        is_ctr_lo = in_range && (iw_req_idx == CTR_LO_IDX);
        is_ctr_hi = in_range && (iw_req_idx == CTR_HI_IDX);
        ro_hit    = in_range && RO_MASK[iw_req_idx];
        is_wr     = csr_op_is_write(op);

        cur_val = '0;
        if (is_ctr_lo)     cur_val = ctr_val[DATA_W-1:0];
        else if (is_ctr_hi) cur_val = ctr_val[2*DATA_W-1:DATA_W];
        else if (in_range) cur_val = csr_q[iw_req_idx];

        case (op)
            CSR_OP_WR:  new_val = iw_req_wdata;
            CSR_OP_SET: new_val = cur_val | iw_req_wdata;
            CSR_OP_CLR: new_val = cur_val & ~iw_req_wdata;
            default:    new_val = cur_val;
        endcase

        req_err   = ~in_range | (is_wr & ro_hit);
        do_update = accept & is_wr & in_range & ~ro_hit;
        ld_lo     = do_update & is_ctr_lo;
        ld_hi     = do_update & is_ctr_hi;
    end

    // Plain storage; counter-aliased entries are never written here.
    always_comb begin
        csr_d = csr_q;
        for (int i = 0; i < NUM_CSR; i++) begin
            if (do_update && !is_ctr_lo && !is_ctr_hi &&
                (iw_req_idx == IDX_W'(i))) begin
                csr_d[i] = new_val;
            end
        end
    end

    // Response FSM and response capture.
    always_comb begin
        state_d     = state_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        if (accept) begin
            state_d     = CSR_ST_RESP;
            rsp_rdata_d = cur_val;
            rsp_err_d   = req_err;
        end else if ((state_q == CSR_ST_RESP) && iw_rsp_ready) begin
            state_d = CSR_ST_IDLE;
        end

        if (iw_flush) begin
            state_d = CSR_ST_IDLE;
        end
    end

    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            state_q     <= CSR_ST_IDLE;
            csr_q       <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            csr_q       <= csr_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    csr_cycle_ctr #(
        .HALF_W (DATA_W)
    ) u_cycle_ctr (
        .iw_clk        (iw_clk),
        .iw_rst_n      (iw_rst_n),
        .iw_ld_lo      (ld_lo),
        .iw_ld_lo_data (new_val),
        .iw_ld_hi      (ld_hi),
        .iw_ld_hi_data (new_val),
        .ow_count      (ctr_val)
    );

    assign ow_rsp_valid = (state_q == CSR_ST_RESP);
    assign ow_rsp_rdata = rsp_rdata_q;
    assign ow_rsp_err   = rsp_err_q;
    assign ow_cycle     = ctr_val;

endmodule
